// File: rtl/binary_mul_pipe.sv
// Pipelined Baugh-Wooley array multiplier with valid/ready handshake.
// Partial-product rows are reduced carry-save across STAGES register levels; the last level does the final add.
module binary_mul_pipe #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               tc,
  output logic [2*WIDTH-1:0] P,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_tc
);

  localparam int PW = 2 * WIDTH;

  // Baugh-Wooley correction constant: 1s at bit WIDTH and bit 2*WIDTH-1.
  localparam logic [PW-1:0] BW_K = {1'b1, {(PW-1){1'b0}}} | ({{(PW-1){1'b0}}, 1'b1} << WIDTH);

  logic advance;

  logic [PW-1:0]    st_s  [STAGES];
  logic [PW-1:0]    st_c  [STAGES];
  logic [WIDTH-1:0] st_a  [STAGES];
  logic [WIDTH-1:0] st_b  [STAGES];
  logic             st_tc [STAGES];
  logic             st_v  [STAGES];

  assign advance  = en && (!out_valid || out_ready);
  assign in_ready = advance;

  // The correction constant is seeded into the sum vector so it costs no extra row.
  assign st_s[0]  = tc ? BW_K : '0;
  assign st_c[0]  = '0;
  assign st_a[0]  = A;
  assign st_b[0]  = B;
  assign st_tc[0] = tc;
  assign st_v[0]  = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = (k * WIDTH) / STAGES;
    localparam int HI = ((k + 1) * WIDTH) / STAGES;

    logic [PW-1:0] cs_s [LO:HI];
    logic [PW-1:0] cs_c [LO:HI];

    assign cs_s[LO] = st_s[k];
    assign cs_c[LO] = st_c[k];

    for (genvar r = LO; r < HI; r++) begin : g_row
      logic [WIDTH-1:0] row;
      logic [PW-1:0]    pp;

      // In signed mode the MSB row and MSB column are complemented, their corner is not.
      for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        localparam logic INV = ((r == WIDTH - 1) != (j == WIDTH - 1));
        assign row[j] = (st_a[k][j] & st_b[k][r]) ^ (st_tc[k] & INV);
      end

      assign pp          = {{WIDTH{1'b0}}, row} << r;
      assign cs_s[r + 1] = cs_s[r] ^ cs_c[r] ^ pp;
      assign cs_c[r + 1] = ((cs_s[r] & cs_c[r]) | (cs_s[r] & pp) | (cs_c[r] & pp)) << 1;
    end

    if (k < STAGES - 1) begin : g_reg
      logic [PW-1:0]    r_s;
      logic [PW-1:0]    r_c;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic             r_tc;
      logic             r_v;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s  <= '0;
          r_c  <= '0;
          r_a  <= '0;
          r_b  <= '0;
          r_tc <= 1'b0;
          r_v  <= 1'b0;
        end else if (advance) begin
          r_s  <= cs_s[HI];
          r_c  <= cs_c[HI];
          r_a  <= st_a[k];
          r_b  <= st_b[k];
          r_tc <= st_tc[k];
          r_v  <= st_v[k];
        end
      end

      assign st_s[k+1]  = r_s;
      assign st_c[k+1]  = r_c;
      assign st_a[k+1]  = r_a;
      assign st_b[k+1]  = r_b;
      assign st_tc[k+1] = r_tc;
      assign st_v[k+1]  = r_v;
    end else begin : g_out
      // P and out_tc only load on a real result so bubbles never disturb the held product.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          P         <= '0;
          out_valid <= 1'b0;
          out_tc    <= 1'b0;
        end else if (advance) begin
          out_valid <= st_v[k];
          if (st_v[k]) begin
            P      <= cs_s[HI] + cs_c[HI];
            out_tc <= st_tc[k];
          end
        end
      end
    end
  end

endmodule
